// File: rtl/entropy_encoder_ctrl.sv
// Tile sequencer in front of entropy_encoder: feeds one symbol record per cycle, flags first/final, flushes and resets.
// Optional byte counter and flag-4 error are built only when ENC_CTRL_BYTE_COUNT_EN is defined.
module entropy_encoder_ctrl #(
  parameter int RANGE_WIDTH     = 16,
  parameter int SYMBOL_WIDTH    = 4,
  parameter int BITSTREAM_WIDTH = 8,
  parameter int RESET_CYCLES    = 1,
  parameter int FLUSH_TIMEOUT   = 1024,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                       top_clk,
  input  logic                       top_reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [RANGE_WIDTH-1:0]     in_fl,
  input  logic [RANGE_WIDTH-1:0]     in_fh,
  input  logic [SYMBOL_WIDTH-1:0]    in_symbol,
  input  logic [SYMBOL_WIDTH:0]      in_nsyms,
  input  logic                       in_bool,
  input  logic                       in_last,
  output logic                       enc_reset,
  output logic                       enc_valid,
  output logic                       enc_flag_first,
  output logic                       enc_final_flag,
  output logic [RANGE_WIDTH-1:0]     enc_fl,
  output logic [RANGE_WIDTH-1:0]     enc_fh,
  output logic [SYMBOL_WIDTH-1:0]    enc_symbol,
  output logic [SYMBOL_WIDTH:0]      enc_nsyms,
  output logic                       enc_bool,
  input  logic [2:0]                 enc_flag_bitstream,
  input  logic [BITSTREAM_WIDTH-1:0] enc_run_len,
  input  logic                       enc_flag_last,
  output logic                       tile_done,
  output logic [CNT_WIDTH-1:0]       tile_sym_count,
  output logic [CNT_WIDTH-1:0]       tile_byte_count,
  output logic                       err_timeout,
  output logic                       err_flag4,
  output logic [1:0]                 dbg_state
);

  // Input handshake: a record transfers on a rising clock edge where in_valid && in_ready.
  // in_ready is registered and high only in RUN; the record appears on enc_* the next cycle.

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam int TW = $clog2(FLUSH_TIMEOUT + 1);

  state_t               state;
  logic [3:0]           rst_cnt;
  logic [TW-1:0]        flush_cnt;
  logic                 first_armed;
  logic [CNT_WIDTH-1:0] sym_cnt;
  logic                 accept;
  logic                 timeout_hit;
  logic                 tile_end;

  assign accept      = in_valid && in_ready;
  assign timeout_hit = (flush_cnt == TW'(FLUSH_TIMEOUT - 1));
  assign tile_end    = (state == ST_FLUSH) && (enc_flag_last || timeout_hit);
  assign dbg_state   = state;

  always_ff @(posedge top_clk or posedge top_reset) begin
    if (top_reset) begin
      state          <= ST_RST;
      rst_cnt        <= '0;
      flush_cnt      <= '0;
      first_armed    <= 1'b1;
      sym_cnt        <= '0;
      enc_reset      <= 1'b1;
      in_ready       <= 1'b0;
      enc_valid      <= 1'b0;
      enc_flag_first <= 1'b0;
      enc_final_flag <= 1'b0;
      enc_fl         <= '0;
      enc_fh         <= '0;
      enc_symbol     <= '0;
      enc_nsyms      <= '0;
      enc_bool       <= 1'b0;
      tile_done      <= 1'b0;
      tile_sym_count <= '0;
      err_timeout    <= 1'b0;
    end else begin
      tile_done      <= 1'b0;
      enc_valid      <= 1'b0;
      enc_flag_first <= 1'b0;
      case (state)
        ST_RST: begin
          first_armed    <= 1'b1;
          sym_cnt        <= '0;
          flush_cnt      <= '0;
          enc_final_flag <= 1'b0;
          if (rst_cnt == 4'(RESET_CYCLES - 1)) begin
            state     <= ST_RUN;
            rst_cnt   <= '0;
            enc_reset <= 1'b0;
            in_ready  <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + 4'd1;
          end
        end
        ST_RUN: begin
          if (accept) begin
            enc_fl         <= in_fl;
            enc_fh         <= in_fh;
            enc_symbol     <= in_symbol;
            enc_nsyms      <= in_nsyms;
            enc_bool       <= in_bool;
            enc_valid      <= 1'b1;
            enc_flag_first <= first_armed;
            first_armed    <= 1'b0;
            sym_cnt        <= sym_cnt + CNT_WIDTH'(1);
            if (in_last) begin
              state    <= ST_FLUSH;
              in_ready <= 1'b0;
            end
          end
        end
        ST_FLUSH: begin
          enc_final_flag <= 1'b1;
          // enc_flag_last takes priority over a timeout landing in the same cycle.
          if (tile_end) begin
            tile_done      <= 1'b1;
            tile_sym_count <= sym_cnt;
            state          <= ST_RST;
            rst_cnt        <= '0;
            enc_reset      <= 1'b1;
            enc_final_flag <= 1'b0;
            if (!enc_flag_last) err_timeout <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + TW'(1);
          end
        end
        default: begin
          state     <= ST_RST;
          rst_cnt   <= '0;
          enc_reset <= 1'b1;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ENC_CTRL_BYTE_COUNT_EN
  logic [CNT_WIDTH-1:0] byte_cnt;
  logic [CNT_WIDTH-1:0] byte_inc;
  logic [CNT_WIDTH-1:0] byte_next;

  // Bytes the encoder emits this cycle, decoded from its bitstream flag and run length.
  always_comb begin
    byte_inc = '0;
    case (enc_flag_bitstream)
      3'd1, 3'd2, 3'd3: byte_inc = CNT_WIDTH'(enc_flag_bitstream);
      3'd5:             byte_inc = CNT_WIDTH'(enc_run_len) + CNT_WIDTH'(1);
      3'd6:             byte_inc = CNT_WIDTH'(enc_run_len) + CNT_WIDTH'(2);
      3'd7:             byte_inc = CNT_WIDTH'(enc_run_len) + CNT_WIDTH'(3);
      default:          byte_inc = '0;
    endcase
  end

  assign byte_next = byte_cnt + byte_inc;

  always_ff @(posedge top_clk or posedge top_reset) begin
    if (top_reset) begin
      byte_cnt        <= '0;
      tile_byte_count <= '0;
      err_flag4       <= 1'b0;
    end else if (state == ST_RST) begin
      byte_cnt <= '0;
    end else begin
      byte_cnt <= byte_next;
      if (enc_flag_bitstream == 3'd4) err_flag4 <= 1'b1;
      if (tile_end) tile_byte_count <= byte_next;
    end
  end
`else
  logic unused_byte_inputs;
  assign unused_byte_inputs = ^{enc_flag_bitstream, enc_run_len};
  assign tile_byte_count    = '0;
  assign err_flag4          = 1'b0;
`endif

endmodule

// File: tb/tb_entropy_encoder_ctrl.sv
// Directed bench for entropy_encoder_ctrl: reset, tile sequencing, gaps, byte counting, timeout and mid-flush reset.
// Outputs are sampled 1 time unit after each rising edge, where inputs are also driven.
module tb_entropy_encoder_ctrl;
  localparam int RW = 16;
  localparam int SW = 4;
  localparam int BW = 8;
  localparam int CW = 32;
`ifdef ENC_CTRL_BYTE_COUNT_EN
  localparam logic BYTE_EN = 1'b1;
`else
  localparam logic BYTE_EN = 1'b0;
`endif

  logic          top_clk;
  logic          top_reset;
  logic          in_valid;
  logic          in_ready;
  logic [RW-1:0] in_fl, in_fh;
  logic [SW-1:0] in_symbol;
  logic [SW:0]   in_nsyms;
  logic          in_bool, in_last;
  logic          enc_reset, enc_valid, enc_flag_first, enc_final_flag;
  logic [RW-1:0] enc_fl, enc_fh;
  logic [SW-1:0] enc_symbol;
  logic [SW:0]   enc_nsyms;
  logic          enc_bool;
  logic [2:0]    enc_flag_bitstream;
  logic [BW-1:0] enc_run_len;
  logic          enc_flag_last;
  logic          tile_done;
  logic [CW-1:0] tile_sym_count, tile_byte_count;
  logic          err_timeout, err_flag4;
  logic [1:0]    dbg_state;

  int errors = 0;
  int checks = 0;

  entropy_encoder_ctrl #(
    .RANGE_WIDTH(RW), .SYMBOL_WIDTH(SW), .BITSTREAM_WIDTH(BW),
    .RESET_CYCLES(2), .FLUSH_TIMEOUT(16), .CNT_WIDTH(CW)
  ) dut (
    .top_clk(top_clk), .top_reset(top_reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fl(in_fl), .in_fh(in_fh), .in_symbol(in_symbol), .in_nsyms(in_nsyms),
    .in_bool(in_bool), .in_last(in_last),
    .enc_reset(enc_reset), .enc_valid(enc_valid),
    .enc_flag_first(enc_flag_first), .enc_final_flag(enc_final_flag),
    .enc_fl(enc_fl), .enc_fh(enc_fh), .enc_symbol(enc_symbol),
    .enc_nsyms(enc_nsyms), .enc_bool(enc_bool),
    .enc_flag_bitstream(enc_flag_bitstream), .enc_run_len(enc_run_len),
    .enc_flag_last(enc_flag_last),
    .tile_done(tile_done), .tile_sym_count(tile_sym_count),
    .tile_byte_count(tile_byte_count),
    .err_timeout(err_timeout), .err_flag4(err_flag4),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  initial top_clk = 1'b0;
  always #5 top_clk = ~top_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, errors=%0d", errors);
    $fatal(1);
  end

  task automatic step();
    @(posedge top_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_rec(input logic [RW-1:0] fl, input logic [RW-1:0] fh,
                           input logic [SW-1:0] sym, input logic [SW:0] ns,
                           input logic bl, input logic last);
    in_valid  = 1'b1;
    in_fl     = fl;
    in_fh     = fh;
    in_symbol = sym;
    in_nsyms  = ns;
    in_bool   = bl;
    in_last   = last;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    int k;
    logic seen;
    top_reset = 1'b1;
    in_valid = 0; in_fl = 0; in_fh = 0; in_symbol = 0; in_nsyms = 0; in_bool = 0; in_last = 0;
    enc_flag_bitstream = 0; enc_run_len = 0; enc_flag_last = 0;
    step();
    step();
    check("rst_enc_reset", enc_reset, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_state", dbg_state, 0);
    check("rst_flags", {enc_valid, enc_flag_first, enc_final_flag, tile_done, err_timeout, err_flag4}, 0);
    check("rst_fields", {enc_fl, enc_fh, enc_symbol, enc_nsyms, enc_bool}, 0);
    check("rst_counts", {tile_sym_count, tile_byte_count}, 0);

    // enc_reset must stay high for two cycles after release
    top_reset = 1'b0;
    step();
    check("rel_c1_enc_reset", enc_reset, 1);
    check("rel_c1_in_ready", in_ready, 0);
    step();
    check("rel_c2_enc_reset", enc_reset, 0);
    check("rel_c2_in_ready", in_ready, 1);
    check("rel_c2_fields", {enc_valid, enc_flag_first, enc_final_flag, enc_fl, enc_fh, enc_symbol, enc_nsyms, enc_bool}, 0);

    // three back-to-back records
    drive_rec(16'h0010, 16'h0020, 4'h1, 5'd5, 1'b0, 1'b0);
    step();
    check("t1_r1_valid", enc_valid, 1);
    check("t1_r1_first", enc_flag_first, 1);
    check("t1_r1_fl", enc_fl, 16'h0010);
    drive_rec(16'h0030, 16'h0040, 4'h2, 5'd5, 1'b1, 1'b0);
    step();
    check("t1_r2_valid", enc_valid, 1);
    check("t1_r2_first", enc_flag_first, 0);
    check("t1_r2_fh_bool", {enc_fh, enc_bool}, {16'h0040, 1'b1});
    drive_rec(16'h0050, 16'h0060, 4'h3, 5'd5, 1'b0, 1'b1);
    step();
    check("t1_r3_valid", enc_valid, 1);
    check("t1_r3_first", enc_flag_first, 0);
    check("t1_r3_sym", enc_symbol, 3);
    check("t1_r3_final", enc_final_flag, 0);
    check("t1_r3_in_ready", in_ready, 0);
    check("t1_r3_state", dbg_state, 2);
    idle_in();
    step();
    check("t1_fl_valid", enc_valid, 0);
    check("t1_fl_final", enc_final_flag, 1);
    check("t1_fl_held", enc_fl, 16'h0050);
    step(); step(); step(); step();
    check("t1_fl_no_done", tile_done, 0);
    enc_flag_last = 1'b1;
    step();
    enc_flag_last = 1'b0;
    check("t1_done", tile_done, 1);
    check("t1_sym_count", tile_sym_count, 3);
    check("t1_byte_count", tile_byte_count, 0);
    check("t1_enc_reset", enc_reset, 1);
    check("t1_final_drop", enc_final_flag, 0);
    check("t1_no_timeout", err_timeout, 0);
    step();
    check("t1_done_pulse", tile_done, 0);
    check("t1_rst_ready", in_ready, 0);
    step();
    check("t1_run_ready", in_ready, 1);
    check("t1_count_held", tile_sym_count, 3);

    // input gaps: first flag survives, fields hold
    step();
    check("t4_idle_valid", enc_valid, 0);
    drive_rec(16'h0111, 16'h0222, 4'h7, 5'd9, 1'b0, 1'b0);
    step();
    check("t4_r1_first", enc_flag_first, 1);
    idle_in();
    step();
    check("t4_gap1_valid", enc_valid, 0);
    check("t4_gap1_first", enc_flag_first, 0);
    check("t4_gap1_held", {enc_fl, enc_fh, enc_symbol, enc_nsyms}, {16'h0111, 16'h0222, 4'h7, 5'd9});
    step();
    check("t4_gap2_valid", enc_valid, 0);
    check("t4_gap2_held", enc_fl, 16'h0111);
    drive_rec(16'h0333, 16'h0444, 4'h8, 5'd9, 1'b1, 1'b1);
    step();
    check("t4_r2_valid", enc_valid, 1);
    check("t4_r2_first", enc_flag_first, 0);
    check("t4_r2_fl", enc_fl, 16'h0333);
    idle_in();
    step();
    check("t4_final", enc_final_flag, 1);
    enc_flag_last = 1'b1;
    step();
    enc_flag_last = 1'b0;
    check("t4_done", tile_done, 1);
    check("t4_sym_count", tile_sym_count, 2);
    step(); step();
    check("t4_run_ready", in_ready, 1);

    // byte counting: flags 2, 5/run3, 7/run0, 4 -> 9 bytes
    drive_rec(16'h0001, 16'h0002, 4'h1, 5'd5, 1'b0, 1'b0);
    enc_flag_bitstream = 3'd2;
    step();
    drive_rec(16'h0003, 16'h0004, 4'h2, 5'd5, 1'b0, 1'b1);
    enc_flag_bitstream = 3'd5; enc_run_len = 8'd3;
    step();
    idle_in();
    enc_flag_bitstream = 3'd7; enc_run_len = 8'd0;
    step();
    enc_flag_bitstream = 3'd4;
    step();
    enc_flag_bitstream = 3'd0;
    enc_flag_last = 1'b1;
    step();
    enc_flag_last = 1'b0;
    check("t3_done", tile_done, 1);
    check("t3_sym_count", tile_sym_count, 2);
    check("t3_byte_count", tile_byte_count, BYTE_EN ? 64'd9 : 64'd0);
    check("t3_err_flag4", err_flag4, BYTE_EN);
    step(); step();
    check("t3_run_ready", in_ready, 1);

    // flush timeout: tile_done after 16 FLUSH cycles
    drive_rec(16'h0aaa, 16'h0bbb, 4'h5, 5'd5, 1'b0, 1'b1);
    step();
    idle_in();
    k = 1;
    seen = 1'b0;
    while (!seen && k < 40) begin
      if (k == 16) check("t5_pre_timeout", {tile_done, err_timeout}, 0);
      step();
      k++;
      if (tile_done) seen = 1'b1;
    end
    check("t5_done_cycle", k, 17);
    check("t5_err_timeout", err_timeout, 1);
    check("t5_sym_count", tile_sym_count, 1);
    check("t5_flag4_sticky", err_flag4, BYTE_EN);
    step(); step();
    check("t5_run_ready", in_ready, 1);
    check("t5_run_state", dbg_state, 1);

    // reset mid-flush abandons the tile
    drive_rec(16'h0ccc, 16'h0ddd, 4'h6, 5'd5, 1'b0, 1'b1);
    step();
    idle_in();
    step(); step();
    top_reset = 1'b1;
    #1;
    check("t6_no_done", tile_done, 0);
    check("t6_counts", {tile_sym_count, tile_byte_count}, 0);
    check("t6_errs", {err_timeout, err_flag4}, 0);
    check("t6_enc_reset", enc_reset, 1);
    check("t6_state", dbg_state, 0);
    check("t6_outs", {in_ready, enc_final_flag, enc_valid, enc_fl}, 0);
    step();
    check("t6_held_no_done", tile_done, 0);
    top_reset = 1'b0;
    step(); step();
    check("t6_run_ready", in_ready, 1);

    // flag_last on the timeout cycle wins: no error
    drive_rec(16'h0eee, 16'h0fff, 4'h9, 5'd10, 1'b1, 1'b1);
    step();
    idle_in();
    for (int i = 1; i < 16; i++) step();
    check("t7_pre_done", tile_done, 0);
    enc_flag_last = 1'b1;
    step();
    enc_flag_last = 1'b0;
    check("t7_done", tile_done, 1);
    check("t7_no_timeout", err_timeout, 0);
    check("t7_sym_count", tile_sym_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
